// File: rtl/multi_cycle_controller.sv
// Multi-cycle sequencer for the accumulator core: FETCH -> DECODE -> optional memory
// phase over one req/ack port, with request timeout and a retired-instruction counter.
//
//  state    | meaning
//  ---------+---------------------------------------------------------------
//  S_IDLE   | no instruction in flight; run=1 starts a fetch
//  S_FETCH  | instruction read at PC; ack loads IR and bumps PC
//  S_DECODE | one cycle; ALU/JMP/NOP retire here, LOAD/STORE go to memory
//  S_MEM_RD | operand read at IR address; ack writes A or B and retires
//  S_MEM_WR | operand store at IR address; ack retires
//  S_ERROR  | memory timeout seen; left only through reset
module multi_cycle_controller #(
  parameter int OPC_W    = 3,
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [OPC_W-1:0] opcode,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             ir_load,
  output logic             pc_inc,
  output logic             rd_mem,
  output logic             wr_A,
  output logic             wr_B,
  output logic             wr_mem,
  output logic             jmp,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEM_RD, S_MEM_WR, S_ERROR
  } state_t;

  localparam logic [OPC_W-1:0] OP_LOAD_A = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_LOAD_B = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_STORE  = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_JMP    = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_ALU    = OPC_W'(7);

  state_t           state;
  logic [7:0]       wait_cnt;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
  logic             ld_b;
  logic             timeout;

  // A request cycle at the wait limit without ack is the timeout; an ack there still wins.
  assign timeout = (wait_cnt == 8'(MAX_WAIT)) && !mem_ack;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      ld_b     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (run) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
          end
        end
        S_FETCH: begin
          if (mem_ack) begin
            state <= S_DECODE;
          end else if (timeout) begin
            state <= S_ERROR;
            err_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_DECODE: begin
          wait_cnt <= '0;
          case (opcode)
            OP_LOAD_A, OP_LOAD_B: begin
              state <= S_MEM_RD;
              ld_b  <= (opcode == OP_LOAD_B);
            end
            OP_STORE: state <= S_MEM_WR;
            default: begin
              state <= S_IDLE;
              cnt_q <= cnt_q + CNT_W'(1);
            end
          endcase
        end
        S_MEM_RD, S_MEM_WR: begin
          if (mem_ack) begin
            state <= S_IDLE;
            cnt_q <= cnt_q + CNT_W'(1);
          end else if (timeout) begin
            state <= S_ERROR;
            err_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_ERROR: state <= S_ERROR;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs are forced low while reset is asserted, before the reset edge lands.
  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    addr_sel = 1'b0;
    ir_load  = 1'b0;
    pc_inc   = 1'b0;
    rd_mem   = 1'b0;
    wr_A     = 1'b0;
    wr_B     = 1'b0;
    wr_mem   = 1'b0;
    jmp      = 1'b0;
    busy     = 1'b0;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          mem_req = 1'b1;
          busy    = 1'b1;
          ir_load = mem_ack;
          pc_inc  = mem_ack;
        end
        S_DECODE: begin
          busy = 1'b1;
          wr_A = (opcode == OP_ALU);
          jmp  = (opcode == OP_JMP);
        end
        S_MEM_RD: begin
          mem_req  = 1'b1;
          rd_mem   = 1'b1;
          addr_sel = 1'b1;
          busy     = 1'b1;
          wr_A     = mem_ack && !ld_b;
          wr_B     = mem_ack && ld_b;
        end
        S_MEM_WR: begin
          mem_req  = 1'b1;
          mem_we   = 1'b1;
          wr_mem   = 1'b1;
          addr_sel = 1'b1;
          busy     = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign err       = err_q && !reset;
  assign instr_cnt = reset ? '0 : cnt_q;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Directed bench for multi_cycle_controller: each step drives inputs, queues the expected
// outputs, and checks them at the following falling edge.
module tb_multi_cycle_controller;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset, run, mem_ack;
  logic [2:0]    opcode;
  logic          mem_req, mem_we, addr_sel, ir_load, pc_inc, rd_mem;
  logic          wr_A, wr_B, wr_mem, jmp, busy, err;
  logic [CW-1:0] instr_cnt;

  multi_cycle_controller #(.OPC_W(3), .MAX_WAIT(15), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_load(ir_load),
    .pc_inc(pc_inc), .rd_mem(rd_mem), .wr_A(wr_A), .wr_B(wr_B), .wr_mem(wr_mem),
    .jmp(jmp), .busy(busy), .err(err), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  // bit order: mem_req mem_we addr_sel ir_load pc_inc rd_mem wr_A wr_B wr_mem jmp busy err
  localparam logic [11:0] O_IDLE   = 12'b0000_0000_0000;
  localparam logic [11:0] O_FETCH  = 12'b1000_0000_0010;
  localparam logic [11:0] O_FETCHA = 12'b1001_1000_0010;
  localparam logic [11:0] O_DEC    = 12'b0000_0000_0010;
  localparam logic [11:0] O_DECALU = 12'b0000_0010_0010;
  localparam logic [11:0] O_DECJMP = 12'b0000_0000_0110;
  localparam logic [11:0] O_RD     = 12'b1010_0100_0010;
  localparam logic [11:0] O_RDA    = 12'b1010_0110_0010;
  localparam logic [11:0] O_RDB    = 12'b1010_0101_0010;
  localparam logic [11:0] O_WR     = 12'b1110_0000_1010;
  localparam logic [11:0] O_ERR    = 12'b0000_0000_0001;

  typedef struct packed {
    logic [11:0]   bits;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t          sb[$];
  logic [CW-1:0] mcnt = '0;
  int            passed = 0;
  int            total = 0;
  logic [11:0]   obs;

  assign obs = {mem_req, mem_we, addr_sel, ir_load, pc_inc, rd_mem,
                wr_A, wr_B, wr_mem, jmp, busy, err};

  task automatic step(input logic rs, input logic rn, input logic [2:0] op,
                      input logic ack, input logic [11:0] exp_bits, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rs; run = rn; opcode = op; mem_ack = ack;
    if (rs) mcnt = '0;
    sb.push_back('{bits: exp_bits, cnt: mcnt});
    @(negedge clk);
    e = sb.pop_front();
    total++;
    assert (obs === e.bits) passed++;
    else $error("FAIL %s outputs: observed %b expected %b", tag, obs, e.bits);
    total++;
    assert (instr_cnt === e.cnt) passed++;
    else $error("FAIL %s instr_cnt: observed %0d expected %0d", tag, instr_cnt, e.cnt);
  endtask

  task automatic retire();
    mcnt = mcnt + 1'b1;
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; mem_ack = 1'b0; opcode = 3'b000;

    // T1: reset then ALU instruction with immediate acks
    step(1, 0, 3'b000, 0, O_IDLE, "reset0");
    step(1, 1, 3'b111, 1, O_IDLE, "reset1");
    step(0, 1, 3'b111, 1, O_IDLE, "t1_idle");
    step(0, 1, 3'b111, 1, O_FETCHA, "t1_fetch");
    step(0, 0, 3'b111, 1, O_DECALU, "t1_decode"); retire();
    step(0, 0, 3'b111, 1, O_IDLE, "t1_done");

    // T2: LOAD_B with ack delayed three cycles
    step(0, 1, 3'b001, 0, O_IDLE, "t2_idle");
    step(0, 1, 3'b001, 1, O_FETCHA, "t2_fetch");
    step(0, 0, 3'b001, 0, O_DEC, "t2_decode");
    for (int i = 0; i < 3; i++) step(0, 0, 3'b001, 0, O_RD, "t2_rd_wait");
    step(0, 0, 3'b001, 1, O_RDB, "t2_rd_ack"); retire();
    step(0, 0, 3'b001, 1, O_IDLE, "t2_done");

    // LOAD_A with immediate ack
    step(0, 1, 3'b000, 0, O_IDLE, "lda_idle");
    step(0, 0, 3'b000, 1, O_FETCHA, "lda_fetch");
    step(0, 0, 3'b000, 0, O_DEC, "lda_decode");
    step(0, 0, 3'b000, 1, O_RDA, "lda_rd_ack"); retire();
    step(0, 0, 3'b000, 0, O_IDLE, "lda_done");

    // T3: STORE then JMP
    step(0, 1, 3'b010, 0, O_IDLE, "st_idle");
    step(0, 1, 3'b010, 1, O_FETCHA, "st_fetch");
    step(0, 1, 3'b010, 0, O_DEC, "st_decode");
    step(0, 1, 3'b010, 0, O_WR, "st_wait0");
    step(0, 1, 3'b010, 0, O_WR, "st_wait1");
    step(0, 1, 3'b010, 1, O_WR, "st_ack"); retire();
    step(0, 1, 3'b100, 0, O_IDLE, "jmp_idle");
    step(0, 1, 3'b100, 0, O_FETCH, "jmp_fetch_wait");
    step(0, 1, 3'b100, 1, O_FETCHA, "jmp_fetch");
    step(0, 0, 3'b100, 0, O_DECJMP, "jmp_decode"); retire();
    step(0, 0, 3'b100, 0, O_IDLE, "jmp_done");

    // Ack on the last allowed wait cycle completes normally
    step(0, 1, 3'b001, 0, O_IDLE, "edge_idle");
    step(0, 0, 3'b001, 1, O_FETCHA, "edge_fetch");
    step(0, 0, 3'b001, 0, O_DEC, "edge_decode");
    for (int i = 0; i < 15; i++) step(0, 0, 3'b001, 0, O_RD, "edge_wait");
    step(0, 0, 3'b001, 1, O_RDB, "edge_ack"); retire();
    step(0, 0, 3'b001, 0, O_IDLE, "edge_done");

    // T5: reset in the middle of an MEM_RD wait
    step(0, 1, 3'b000, 0, O_IDLE, "t5_idle");
    step(0, 0, 3'b000, 1, O_FETCHA, "t5_fetch");
    step(0, 0, 3'b000, 0, O_DEC, "t5_decode");
    step(0, 0, 3'b000, 0, O_RD, "t5_wait0");
    step(0, 0, 3'b000, 0, O_RD, "t5_wait1");
    step(1, 0, 3'b000, 1, O_IDLE, "t5_reset");
    step(0, 0, 3'b000, 1, O_IDLE, "t5_after");

    // T6: sixteen NOPs wrap the 4-bit counter, then run=0 keeps the port quiet
    for (int n = 0; n < 16; n++) begin
      step(0, 1, 3'b011, 0, O_IDLE, "t6_idle");
      step(0, 0, 3'b011, 1, O_FETCHA, "t6_fetch");
      step(0, 0, 3'b011, 1, O_DEC, "t6_decode"); retire();
    end
    for (int i = 0; i < 3; i++) step(0, 0, 3'b011, 1, O_IDLE, "t6_idle_run0");

    // T4: no ack in FETCH times out after 16 request cycles; error holds until reset
    step(0, 1, 3'b111, 0, O_IDLE, "t4_idle");
    for (int i = 0; i < 16; i++) step(0, 1, 3'b111, 0, O_FETCH, "t4_fetch_wait");
    for (int i = 0; i < 4; i++) step(0, 1, 3'b111, 1, O_ERR, "t4_error");
    step(1, 1, 3'b111, 0, O_IDLE, "t4_reset");
    step(0, 0, 3'b111, 0, O_IDLE, "t4_after");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
